// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: oversampled deframer feeding a registered first-word-fall-through FIFO,
// with sticky frame/overrun flags and a level interrupt.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CW           = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          rx_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          rx_valid_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          frame_err_o,
  output logic          overrun_o,
  input  logic          clr_err_i,
  output logic          irq_o
);

  localparam int unsigned BW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic          rx_meta_q, rxs_q;
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bitc_q, bitc_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          ferr_evt_q, ferr_evt_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          pop, push_ok, full;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bitc_d     = bitc_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    ferr_evt_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_q == BW'(HALF - 1)) begin
          baud_d  = '0;
          bitc_d  = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BW'(CLKS_PER_BIT - 1)) begin
          baud_d  = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bitc_q == 3'd7) state_d = S_STOP;
          else                bitc_d  = bitc_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BW'(CLKS_PER_BIT - 1)) begin
          baud_d = '0;
          if (rxs_q) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_evt_d = 1'b1;
            state_d    = S_BREAK;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Head register is reloaded from the slot after the head on a pop, or from the
  // incoming byte when the FIFO is (or becomes) empty.
  always_comb begin
    pop         = rd_en_i && (count_q != '0);
    full        = (count_q == CW'(FIFO_DEPTH));
    push_ok     = push_q && (!full || pop);
    wr_ptr_d    = wr_ptr_q + AW'(push_ok);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push_ok) - CW'(pop);
    rd_data_d   = rd_data_q;
    if (pop) begin
      if (count_q > CW'(1))  rd_data_d = mem_q[rd_ptr_q + AW'(1)];
      else if (push_ok)      rd_data_d = shift_q;
    end else if ((count_q == '0) && push_ok) begin
      rd_data_d = shift_q;
    end
    frame_err_d = ferr_evt_q || (frame_err_q && !clr_err_i);
    overrun_d   = (push_q && !push_ok) || (overrun_q && !clr_err_i);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bitc_q      <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      ferr_evt_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bitc_q      <= bitc_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      ferr_evt_q  <= ferr_evt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data_o    = rd_data_q;
  assign rx_valid_o   = (count_q != '0);
  assign fifo_count_o = count_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign irq_o        = rx_valid_o | frame_err_q | overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle, plus directed literals.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  // start-edge to visible-head latency: 2 sync + 1 detect + half bit + 9 bits + push + register
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_i = 1'b1;
  logic          rd_en_i = 1'b0;
  logic          clr_err_i = 1'b0;
  logic [7:0]    rd_data_o;
  logic          rx_valid_o;
  logic [CW-1:0] fifo_count_o;
  logic          frame_err_o, overrun_o, irq_o;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CW(CW)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .rx_i         (rx_i),
    .rd_en_i      (rd_en_i),
    .rd_data_o    (rd_data_o),
    .rx_valid_o   (rx_valid_o),
    .fifo_count_o (fifo_count_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .clr_err_i    (clr_err_i),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] data;
    bit         ferr;
  } ev_t;

  ev_t        sched[$];
  logic [7:0] mq[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr  = 1'b0;
  int         cyc    = 0;
  int         n_assert = 0;
  int         n_fail   = 0;
  bit         m_pop, m_push, m_fe;
  logic [7:0] m_pb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, frame outcomes scheduled by the sender.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      sched.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      m_pop  = rd_en_i && (mq.size() > 0);
      m_push = 1'b0;
      m_fe   = 1'b0;
      m_pb   = '0;
      if (sched.size() > 0 && sched[0].due == cyc) begin
        if (sched[0].ferr) m_fe = 1'b1;
        else begin m_push = 1'b1; m_pb = sched[0].data; end
        void'(sched.pop_front());
      end
      if (clr_err_i) begin m_ferr = 1'b0; m_ovr = 1'b0; end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_pb);
        else m_ovr = 1'b1;
      end
      if (m_fe) m_ferr = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rx_valid", {31'd0, rx_valid_o}, {31'd0, mq.size() > 0});
      check("fifo_count", 32'(fifo_count_o), 32'(mq.size()));
      if (mq.size() > 0) check("rd_data", 32'(rd_data_o), 32'(mq[0]));
      check("frame_err", {31'd0, frame_err_o}, {31'd0, m_ferr});
      check("overrun", {31'd0, overrun_o}, {31'd0, m_ovr});
      check("irq", {31'd0, irq_o}, {31'd0, (mq.size() > 0) || m_ferr || m_ovr});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    sched.push_back('{due: cyc + LAT, data: b, ferr: !stop_ok});
    rx_i = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cycles(CPB);
    end
    rx_i = stop_ok;
    wait_cycles(CPB);
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    check("pop_valid", {31'd0, rx_valid_o}, 32'd1);
    check("pop_data", 32'(rd_data_o), 32'(exp));
    rd_en_i = 1'b1;
    wait_cycles(1);
    rd_en_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err_i = 1'b1;
    wait_cycles(1);
    clr_err_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(rd_data_o), 32'd0);
    check({tag, "_valid"}, {31'd0, rx_valid_o}, 32'd0);
    check({tag, "_count"}, 32'(fifo_count_o), 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err_o}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun_o}, 32'd0);
    check({tag, "_irq"}, {31'd0, irq_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    wait_cycles(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cycles(5);

    // 1: five back-to-back bytes, no pops
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    check("t1_count", 32'(fifo_count_o), 32'd4);
    check("t1_overrun", {31'd0, overrun_o}, 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    check("t1_empty", {31'd0, rx_valid_o}, 32'd0);
    pulse_clr();
    check("t1_clr", {31'd0, overrun_o}, 32'd0);
    wait_cycles(5);

    // 2: latency of a single byte
    n0 = cyc;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        wait_cycles(LAT - 1);
        check("t2_not_yet", {31'd0, rx_valid_o}, 32'd0);
        wait_cycles(1);
        check("t2_rise", {31'd0, rx_valid_o}, 32'd1);
      end
    join
    check("t2_lat", 32'(LAT), 32'd156);
    check("t2_data", 32'(rd_data_o), 32'hA5);
    check("t2_irq", {31'd0, irq_o}, 32'd1);
    pop_expect(8'hA5);
    check("t2_count", 32'(fifo_count_o), 32'd0);
    check("t2_irq0", {31'd0, irq_o}, 32'd0);
    wait_cycles(5);

    // 3: short glitch on the line
    rx_i = 1'b0;
    wait_cycles(5);
    rx_i = 1'b1;
    wait_cycles(30);
    check("t3_count", 32'(fifo_count_o), 32'd0);
    check("t3_irq", {31'd0, irq_o}, 32'd0);
    send_byte(8'h3C, 1'b1);
    pop_expect(8'h3C);
    wait_cycles(5);

    // 4: framing error followed by a held-low line
    send_byte(8'h55, 1'b0);
    wait_cycles(40);
    check("t4_ferr", {31'd0, frame_err_o}, 32'd1);
    check("t4_count", 32'(fifo_count_o), 32'd0);
    rx_i = 1'b1;
    wait_cycles(20);
    send_byte(8'h7E, 1'b1);
    pop_expect(8'h7E);
    pulse_clr();
    check("t4_clr", {31'd0, frame_err_o}, 32'd0);
    wait_cycles(5);

    // 5: pop in the exact push cycle while full
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("t5_full", 32'(fifo_count_o), 32'd4);
    fork
      send_byte(8'h99, 1'b1);
      begin
        wait_cycles(LAT - 1);
        pop_expect(8'h11);
      end
    join
    check("t5_count", 32'(fifo_count_o), 32'd4);
    check("t5_ovr", {31'd0, overrun_o}, 32'd0);
    pop_expect(8'h22);
    pop_expect(8'h33);
    pop_expect(8'h44);
    pop_expect(8'h99);
    check("t5_empty", {31'd0, rx_valid_o}, 32'd0);
    wait_cycles(5);

    // 6: reset in the middle of a frame
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    check("t6_pre", 32'(fifo_count_o), 32'd2);
    rx_i = 1'b0;
    wait_cycles(CPB);
    rx_i = 1'b0;
    wait_cycles(CPB);
    rx_i = 1'b0;
    wait_cycles(CPB / 2);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    wait_cycles(3);
    rx_i = 1'b1;
    rst = 1'b0;
    wait_cycles(20);
    send_byte(8'h12, 1'b1);
    check("t6_count", 32'(fifo_count_o), 32'd1);
    check("t6_data", 32'(rd_data_o), 32'h12);
    pop_expect(8'h12);
    check("t6_empty", {31'd0, rx_valid_o}, 32'd0);
    wait_cycles(5);
    if (n0 < 0) n_fail++;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
